// File: rtl/golay_splusi_search.sv
// S-plus-B-row search stage of the Golay PROM ECC decoder: finds the lowest-index
// parity row (or S itself) whose XOR with the syndrome is light enough to be an error pattern.
module golay_splusi_search #(
  parameter int              K         = 12,
  parameter logic [K*K-1:0]  B_ROWS    = {12'h7FF, 12'hEE2, 12'hDC5, 12'hB8B,
                                          12'hF16, 12'hE2D, 12'hC5B, 12'h8B7,
                                          12'h96E, 12'hADC, 12'hDB8, 12'hB71},
  parameter int              WMAX      = 2,
  parameter int              WMAX_S    = 3,
  parameter bit              INCLUDE_S = 1'b1,
  parameter int              CW        = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [K-1:0]             S,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [2*K-1:0]           E,
  output logic                     FOUND,
  output logic [$clog2(K+2)-1:0]   IDX,
  input  logic                     CNT_CLR,
  output logic [CW-1:0]            CNT_SRCH,
  output logic [CW-1:0]            CNT_HIT
);

  localparam int IW = $clog2(K+2);
  localparam int PW = $clog2(K+1);

  // Handshake: a word moves across an interface only on a cycle where VALID and READY
  // are both high. The whole pipe advances together whenever the output register is
  // empty or being drained, so IN_READY is that advance term and bubbles are never squeezed.
  logic adv;
  assign adv      = !OUT_VALID || OUT_READY;
  assign IN_READY = adv;

  function automatic logic [PW-1:0] popcnt(input logic [K-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < K; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  // Row 1 lives in the most significant K bits of B_ROWS.
  function automatic logic [K-1:0] brow(input int i);
    return B_ROWS[K*K-1-i*K -: K];
  endfunction

  logic           p1_valid;
  logic [K-1:0]   p1_s;
  logic [K-1:0]   p1_x [K];

  logic           p2_valid;
  logic [K-1:0]   p2_s;
  logic [K-1:0]   p2_x [K];
  logic [K-1:0]   p2_hit;
  logic           p2_s_hit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p1_valid <= 1'b0;
      p1_s     <= '0;
      for (int i = 0; i < K; i++) p1_x[i] <= '0;
    end else if (adv) begin
      p1_valid <= IN_VALID;
      p1_s     <= S;
      for (int i = 0; i < K; i++) p1_x[i] <= S ^ brow(i);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p2_valid <= 1'b0;
      p2_s     <= '0;
      p2_hit   <= '0;
      p2_s_hit <= 1'b0;
      for (int i = 0; i < K; i++) p2_x[i] <= '0;
    end else if (adv) begin
      p2_valid <= p1_valid;
      p2_s     <= p1_s;
      p2_s_hit <= INCLUDE_S && (popcnt(p1_s) <= PW'(WMAX_S));
      for (int i = 0; i < K; i++) begin
        p2_x[i]   <= p1_x[i];
        p2_hit[i] <= popcnt(p1_x[i]) <= PW'(WMAX);
      end
    end
  end

  logic [2*K-1:0] sel_e;
  logic           sel_found;
  logic [IW-1:0]  sel_idx;
  logic [K-1:0]   unit_v;

  // Walk from row K down to row 1 so the lowest-index hit is the last one written; S overrides all.
  always_comb begin
    sel_e     = '1;
    sel_found = 1'b0;
    sel_idx   = '1;
    unit_v    = '0;
    for (int i = K-1; i >= 0; i--) begin
      if (p2_hit[i]) begin
        unit_v          = '0;
        unit_v[K-1-i]   = 1'b1;
        sel_e           = {p2_x[i], unit_v};
        sel_found       = 1'b1;
        sel_idx         = IW'(i+1);
      end
    end
    if (p2_s_hit) begin
      sel_e     = {p2_s, {K{1'b0}}};
      sel_found = 1'b1;
      sel_idx   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      E         <= '1;
      FOUND     <= 1'b0;
      IDX       <= '1;
    end else if (adv) begin
      OUT_VALID <= p2_valid;
      if (p2_valid) begin
        E     <= sel_e;
        FOUND <= sel_found;
        IDX   <= sel_idx;
      end
    end
  end

  logic xfer;
  assign xfer = OUT_VALID && OUT_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CNT_SRCH <= '0;
      CNT_HIT  <= '0;
    end else if (CNT_CLR) begin
      CNT_SRCH <= '0;
      CNT_HIT  <= '0;
    end else if (xfer) begin
      if (CNT_SRCH != '1) CNT_SRCH <= CNT_SRCH + 1'b1;
      if (FOUND && (CNT_HIT != '1)) CNT_HIT <= CNT_HIT + 1'b1;
    end
  end

endmodule

// File: tb/tb_golay_splusi_search.sv
// Directed bench for golay_splusi_search: hand-computed vector table on a default instance and an
// INCLUDE_S=0 / CW=2 instance, plus backpressure, counter-clear and mid-stream reset sequences.
module tb_golay_splusi_search;
  localparam int K = 12;
  localparam int W = 2*K + 1 + 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;
  logic [11:0] s = '0;

  logic        in_ready, out_valid, found;
  logic [23:0] e;
  logic [3:0]  idx;
  logic [15:0] cnt_srch, cnt_hit;

  logic        in_ready_ns, out_valid_ns, found_ns;
  logic [23:0] e_ns;
  logic [3:0]  idx_ns;
  logic [1:0]  cnt_srch_ns, cnt_hit_ns;

  golay_splusi_search dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready), .S(s),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .E(e), .FOUND(found), .IDX(idx),
    .CNT_CLR(cnt_clr), .CNT_SRCH(cnt_srch), .CNT_HIT(cnt_hit)
  );

  golay_splusi_search #(.INCLUDE_S(1'b0), .CW(2)) dut_ns (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready_ns), .S(s),
    .OUT_VALID(out_valid_ns), .OUT_READY(out_ready), .E(e_ns), .FOUND(found_ns), .IDX(idx_ns),
    .CNT_CLR(cnt_clr), .CNT_SRCH(cnt_srch_ns), .CNT_HIT(cnt_hit_ns)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] s;
    logic [23:0] e;
    logic        found;
    logic [3:0]  idx;
    logic [23:0] e_ns;
    logic [3:0]  idx_ns;
  } vec_t;

  vec_t vecs[$];
  logic [W-1:0] exp_q[$];
  bit           nsf_q[$];
  int total = 0;
  int bad = 0;
  int exp_srch = 0, exp_hit = 0, exp_srch_ns = 0, exp_hit_ns = 0;

  logic [11:0] rows [12] = '{12'h7FF, 12'hEE2, 12'hDC5, 12'hB8B, 12'hF16, 12'hE2D,
                             12'hC5B, 12'h8B7, 12'h96E, 12'hADC, 12'hDB8, 12'hB71};

  function automatic int wt(input logic [11:0] v);
    int c;
    c = 0;
    while (v != 0) begin
      v = v & (v - 12'd1);
      c++;
    end
    return c;
  endfunction

  function automatic bit is_nohit(input logic [11:0] v);
    if (wt(v) <= 3) return 1'b0;
    for (int r = 0; r < 12; r++) if (wt(v ^ rows[r]) <= 2) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [11:0] sv, input logic [23:0] ev, input logic fv,
                         input logic [3:0] iv, input logic [23:0] env, input logic [3:0] inv);
    vec_t t;
    t.s = sv; t.e = ev; t.found = fv; t.idx = iv; t.e_ns = env; t.idx_ns = inv;
    vecs.push_back(t);
  endtask

  task automatic bump(input bit f, input bit fns);
    if (exp_srch < 65535) exp_srch++;
    if (f && exp_hit < 65535) exp_hit++;
    if (exp_srch_ns < 3) exp_srch_ns++;
    if (fns && exp_hit_ns < 3) exp_hit_ns++;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_srch"}, 32'(cnt_srch), 32'(exp_srch));
    chk({tag, "_hit"}, 32'(cnt_hit), 32'(exp_hit));
    chk({tag, "_srch_ns"}, 32'(cnt_srch_ns), 32'(exp_srch_ns));
    chk({tag, "_hit_ns"}, 32'(cnt_hit_ns), 32'(exp_hit_ns));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int got;
    int sent, recv, cyc, spur;
    bit saw_stall;

    //       S       E main     F  IDX    E no-S     IDX no-S
    add_vec(12'h001, 24'h001000, 1, 4'h0, 24'hFFFFFF, 4'hF);
    add_vec(12'h7FF, 24'h000800, 1, 4'h1, 24'h000800, 4'h1);
    add_vec(12'hEE1, 24'h003400, 1, 4'h2, 24'h003400, 4'h2);
    add_vec(12'h000, 24'h000000, 1, 4'h0, 24'hFFFFFF, 4'hF);
    add_vec(12'h007, 24'h007000, 1, 4'h0, 24'hFFFFFF, 4'hF);
    add_vec(12'h00F, 24'hFFFFFF, 0, 4'hF, 24'hFFFFFF, 4'hF);
    add_vec(12'hDC4, 24'h001200, 1, 4'h3, 24'h001200, 4'h3);
    add_vec(12'hB71, 24'h000001, 1, 4'hC, 24'h000001, 4'hC);
    add_vec(12'hEE5, 24'hFFFFFF, 0, 4'hF, 24'hFFFFFF, 4'hF);
    got = 0;
    for (int v = 16; v < 4096 && got < 2; v++) begin
      if (is_nohit(12'(v))) begin
        add_vec(12'(v), 24'hFFFFFF, 0, 4'hF, 24'hFFFFFF, 4'hF);
        got++;
      end
    end
    chk("model_nohit_found", 32'(got), 32'd2);

    // Reset state
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_e", 32'(e), 32'hFFFFFF);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_idx", 32'(idx), 32'hF);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid_ns", 32'(out_valid_ns), 32'd0);
    chk_counts("rst");
    rst_n = 1'b1;
    tick();

    // Table of single transactions
    for (int i = 0; i < vecs.size(); i++) begin
      s = vecs[i].s;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 8) begin
        tick();
        n++;
      end
      chk($sformatf("vec%0d_latency", i), 32'(n), 32'd3);
      chk($sformatf("vec%0d_e", i), 32'(e), 32'(vecs[i].e));
      chk($sformatf("vec%0d_found", i), 32'(found), 32'(vecs[i].found));
      chk($sformatf("vec%0d_idx", i), 32'(idx), 32'(vecs[i].idx));
      chk($sformatf("vec%0d_valid_ns", i), 32'(out_valid_ns), 32'd1);
      chk($sformatf("vec%0d_e_ns", i), 32'(e_ns), 32'(vecs[i].e_ns));
      chk($sformatf("vec%0d_idx_ns", i), 32'(idx_ns), 32'(vecs[i].idx_ns));
      chk($sformatf("vec%0d_found_ns", i), 32'(found_ns), 32'(vecs[i].idx_ns != 4'hF));
      bump(vecs[i].found, vecs[i].idx_ns != 4'hF);
      tick();
      chk($sformatf("vec%0d_drop", i), 32'(out_valid), 32'd0);
      chk_counts($sformatf("vec%0d_cnt", i));
    end

    // Clear colliding with a transfer: clear must win
    s = 12'h001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      tick();
      n++;
    end
    chk("clr_latency", 32'(n), 32'd3);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_srch = 0; exp_hit = 0; exp_srch_ns = 0; exp_hit_ns = 0;
    chk_counts("clr");

    // Back-to-back stream of 6 with OUT_READY low on cycles 2-6
    sent = 0; recv = 0; cyc = 0; saw_stall = 1'b0;
    while (recv < 6 && cyc < 60) begin
      out_ready = !(cyc >= 2 && cyc <= 6);
      in_valid  = (sent < 6);
      s         = (sent < 6) ? vecs[sent].s : 12'h000;
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("stream_spurious_c%0d", cyc), 32'(out_valid), 32'd0);
        end else begin
          chk($sformatf("stream_out_c%0d", cyc), 32'({e, found, idx}), 32'(exp_q[0]));
          if (out_ready) begin
            bump(exp_q[0][4], nsf_q[0]);
            void'(exp_q.pop_front());
            void'(nsf_q.pop_front());
            recv++;
          end
        end
      end
      if (!in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) begin
        exp_q.push_back({vecs[sent].e, vecs[sent].found, vecs[sent].idx});
        nsf_q.push_back(vecs[sent].idx_ns != 4'hF);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_recv", 32'(recv), 32'd6);
    chk("stream_sent", 32'(sent), 32'd6);
    chk("stream_stall_seen", 32'(saw_stall), 32'd1);
    chk("stream_srch_is_6", 32'(cnt_srch), 32'd6);
    chk_counts("stream");

    // Reset with entries in flight
    for (int k = 0; k < 3; k++) begin
      s = vecs[k].s;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_srch = 0; exp_hit = 0; exp_srch_ns = 0; exp_hit_ns = 0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_e", 32'(e), 32'hFFFFFF);
    chk("midrst_idx", 32'(idx), 32'hF);
    chk("midrst_out_valid_ns", 32'(out_valid_ns), 32'd0);
    chk_counts("midrst");
    tick();
    rst_n = 1'b1;
    spur = 0;
    repeat (5) begin
      tick();
      if (out_valid || out_valid_ns) spur++;
    end
    chk("post_rst_spurious", 32'(spur), 32'd0);
    s = 12'hB71;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      tick();
      n++;
    end
    chk("post_rst_latency", 32'(n), 32'd3);
    chk("post_rst_e", 32'(e), 32'h000001);
    chk("post_rst_idx", 32'(idx), 32'hC);
    bump(1'b1, 1'b1);
    tick();
    chk_counts("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
